vga_rx_decoder: RTL and testbench
=================================

VGA_RX_DECODER -- requirements
Module: vga_rx_decoder

Interface
REQ-001 Parameter LOCK_FRAMES, default 2, is the number of consecutive error-free frames required to reach lock.
REQ-002 Parameter TIMEOUT, default 64, is the number of CLOCK_50 cycles without a VGA_CLK rising edge after which link loss is declared.
REQ-003 CLOCK_50  input  1  is the single system clock; every register in the block is clocked by CLOCK_50.
REQ-004 reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 VGA_CLK  input  1  is the pixel clock, treated as data and sampled in the CLOCK_50 domain.
REQ-006 VGA_HS, VGA_VS  input  1 each  are the horizontal and vertical syncs, both active-low.
REQ-007 VGA_BLANK_N  input  1  is high during active video.
REQ-008 x_rx  output  10  is the decoded active column, 0..639.
REQ-009 y_rx  output  10  is the decoded active line, 0..479.
REQ-010 ativo_rx  output  1  is high while the current decoded pixel is active.
REQ-011 pixel_valid  output  1  is a one-cycle pulse per decoded pixel tick.
REQ-012 frame_start  output  1  is a one-cycle pulse on each VGA_VS falling edge.
REQ-013 locked  output  1  is high while the FSM is in TRAVADO.
REQ-014 erro  output  1  is a sticky timing-error flag.
REQ-015 frames  output  16  is a wrapping count of frames received while locked.

Function
REQ-016 All four inputs other than reset_n shall be registered once, and one further previous-value stage shall be kept for edge detection.
REQ-017 A pixel tick shall be one VGA_CLK rising edge: the previous sample is 0 and the current sample is 1.
REQ-018 hcnt, 10 bits, shall clear on the VGA_HS falling edge; otherwise it shall increment on each tick and saturate at 1023.
REQ-019 vcnt, 10 bits, shall clear on the VGA_VS falling edge; otherwise it shall increment on each VGA_HS falling edge and saturate at 1023.
REQ-020 xa shall clear on the VGA_HS falling edge and increment on each tick that has VGA_BLANK_N high.
REQ-021 ya shall clear on the VGA_VS falling edge and increment on each VGA_HS falling edge that ends a line in which xa was nonzero.
REQ-022 On each tick, x_rx shall equal xa, y_rx shall equal ya, and ativo_rx shall equal the sampled VGA_BLANK_N.
REQ-023 The latency from the VGA_CLK rising edge at the pin to pixel_valid shall be 3 CLOCK_50 cycles.
REQ-024 Line check: at the VGA_HS falling edge, hcnt shall be 799 and xa shall be 0 or 640; any other value is a line error.
REQ-025 Frame check: at the VGA_VS falling edge, vcnt shall be 524 and ya shall be 480; any other value is a frame error.
REQ-026 The FSM shall have three states: BUSCA, SINCRONIZANDO and TRAVADO.
REQ-027 In BUSCA, the first VGA_VS falling edge shall move the FSM to SINCRONIZANDO and clear the good-frame counter.
REQ-028 In SINCRONIZANDO, each error-free frame end shall increment the good-frame counter; the FSM shall move to TRAVADO when the counter reaches LOCK_FRAMES.
REQ-029 In SINCRONIZANDO or TRAVADO, any line error, frame error or timeout shall move the FSM to BUSCA and set erro.
REQ-030 erro shall clear only on reset.
REQ-031 frames shall increment on each frame_start while in TRAVADO and wrap from 65535 to 0.
REQ-032 The timeout counter shall clear on each tick and saturate at TIMEOUT; reaching TIMEOUT is a timeout error.
REQ-033 When a line error and a frame end occur in the same cycle, the error shall take precedence.
REQ-034 In BUSCA, the checks shall run but shall not set erro.

Reset
REQ-035 While reset_n is low, every register shall clear asynchronously.
REQ-036 The reset value of every output shall be 0.
REQ-037 The FSM shall reset to BUSCA.
REQ-038 After reset_n deasserts mid-frame, the block shall wait for a full VS-to-VS frame before counting toward lock.

Structure
REQ-039 A shared package vga_pkg shall hold H_TOTAL=800, H_ATIVO=640, V_TOTAL=525, V_ATIVO=480 and the FSM state enum.
REQ-040 The transmitter timing generator shall use the same vga_pkg constants.
REQ-041 One sub-module, detector_borda, shall provide the register-plus-edge-detect stage and be instantiated four times.

Verification
REQ-042 Two clean 640x480 frames from a bench generator -> locked rises 3 cycles after the second VS fall; erro stays 0.
REQ-043 First active pixel after lock -> pixel_valid with x_rx=0, y_rx=0, ativo_rx=1; last active pixel -> x_rx=639, y_rx=479.
REQ-044 One line of 799 ticks injected while locked -> erro=1 and locked=0 at that HS fall; relock occurs after 2 clean frames.
REQ-045 VGA_CLK held low for 64 cycles while locked -> locked=0 and erro=1.
REQ-046 reset_n pulsed low mid-frame -> all outputs read 0 immediately; lock is reached after the next full frame plus LOCK_FRAMES frames.
REQ-047 Frames counter preloaded via force to 65535, then one frame -> frames=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants and decoder types, used by both the
// transmitter timing generator and the receive-side decoder.
package vga_pkg;

  localparam int H_TOTAL = 800;
  localparam int H_ATIVO = 640;
  localparam int V_TOTAL = 525;
  localparam int V_ATIVO = 480;

  typedef enum logic [1:0] {
    BUSCA,
    SINCRONIZANDO,
    TRAVADO
  } estado_t;

  // Single-cycle events derived from the sampled VGA pins.
  typedef struct packed {
    logic tick;
    logic hs_fall;
    logic vs_fall;
    logic blank;
  } eventos_t;

endpackage

// File: rtl/vga_rx_decoder_if.sv
// Bundle of VGA pins entering the decoder and the decoded results leaving it.
interface vga_rx_decoder_if;

  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic [9:0]  x_rx;
  logic [9:0]  y_rx;
  logic        ativo_rx;
  logic        pixel_valid;
  logic        frame_start;
  logic        locked;
  logic        erro;
  logic [15:0] frames;

  modport master (
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  x_rx, y_rx, ativo_rx, pixel_valid, frame_start, locked, erro, frames
  );

  modport slave (
    input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
    output x_rx, y_rx, ativo_rx, pixel_valid, frame_start, locked, erro, frames
  );

endinterface

// File: rtl/detector_borda.sv
// Samples one asynchronous VGA pin and keeps the previous sample so the
// parent can form rising/falling edge strobes.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sample,
  output logic prev
);

  // NOTE: sequential state uses non-blocking assignments so prev really sees
  // the old sample; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sample <= din;
      prev   <= sample;
    end
  end

endmodule

// File: rtl/vga_rx_decoder.sv
// Receive-side VGA decoder: recovers pixel coordinates from the sampled pins,
// checks line/frame geometry and tracks sync lock with a three-state FSM.
module vga_rx_decoder
  import vga_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 64,
  parameter int H_TOT       = H_TOTAL,
  parameter int H_ACT       = H_ATIVO,
  parameter int V_TOT       = V_TOTAL,
  parameter int V_ACT       = V_ATIVO
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  vga_rx_decoder_if.slave vga
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam int              GW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]      CNT_MAX  = '1;
  localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT);
  localparam logic [GW-1:0]   GOOD_MAX = GW'(LOCK_FRAMES);

  logic clk_s, clk_p, hs_s, hs_p, vs_s, vs_p, blank_s, blank_prev_unused;

  detector_borda u_det_clk   (.clk(CLOCK_50), .rst_n(reset_n), .din(vga.VGA_CLK),
                              .sample(clk_s),   .prev(clk_p));
  detector_borda u_det_hs    (.clk(CLOCK_50), .rst_n(reset_n), .din(vga.VGA_HS),
                              .sample(hs_s),    .prev(hs_p));
  detector_borda u_det_vs    (.clk(CLOCK_50), .rst_n(reset_n), .din(vga.VGA_VS),
                              .sample(vs_s),    .prev(vs_p));
  detector_borda u_det_blank (.clk(CLOCK_50), .rst_n(reset_n), .din(vga.VGA_BLANK_N),
                              .sample(blank_s), .prev(blank_prev_unused));

  eventos_t      ev_d, ev_q;
  estado_t       state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [9:0]    hcnt, vcnt, xa, ya;
  logic [TW-1:0] to_cnt;
  logic [9:0]    x_q, y_q;
  logic          ativo_q, pv_q, fs_q, erro_q;
  logic [15:0]   frames_q;
  logic          line_err, frame_err, timeout, erro_set;

  always_comb begin
    ev_d.tick    = clk_s & ~clk_p;
    ev_d.hs_fall = ~hs_s & hs_p;
    ev_d.vs_fall = ~vs_s & vs_p;
    ev_d.blank   = blank_s;
  end

  // Geometry checks and FSM; errors win over a simultaneous frame end.
  always_comb begin
    // NOTE: every combinational output is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    good_d    = good_q;
    erro_set  = 1'b0;
    line_err  = ev_q.hs_fall &&
                !((hcnt == 10'(H_TOT - 1)) && (xa == '0 || xa == 10'(H_ACT)));
    frame_err = ev_q.vs_fall && !((vcnt == 10'(V_TOT - 1)) && (ya == 10'(V_ACT)));
    timeout   = (to_cnt == TO_MAX);
    unique case (state_q)
      BUSCA: begin
        if (ev_q.vs_fall) begin
          state_d = SINCRONIZANDO;
          good_d  = '0;
        end
      end
      SINCRONIZANDO: begin
        if (line_err || frame_err || timeout) begin
          state_d  = BUSCA;
          erro_set = 1'b1;
        end else if (ev_q.vs_fall) begin
          good_d = good_q + GW'(1);
          if (good_d == GOOD_MAX) state_d = TRAVADO;
        end
      end
      TRAVADO: begin
        if (line_err || frame_err || timeout) begin
          state_d  = BUSCA;
          erro_set = 1'b1;
        end
      end
      default: state_d = BUSCA;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ev_q     <= '0;
      state_q  <= BUSCA;
      good_q   <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      xa       <= '0;
      ya       <= '0;
      to_cnt   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ativo_q  <= 1'b0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
      erro_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      ev_q    <= ev_d;
      state_q <= state_d;
      good_q  <= good_d;
      erro_q  <= erro_q | erro_set;
      pv_q    <= ev_q.tick;
      fs_q    <= ev_q.vs_fall;

      if (ev_q.hs_fall)                       hcnt <= '0;
      else if (ev_q.tick && hcnt != CNT_MAX)  hcnt <= hcnt + 10'd1;

      if (ev_q.vs_fall)                        vcnt <= '0;
      else if (ev_q.hs_fall && vcnt != CNT_MAX) vcnt <= vcnt + 10'd1;

      if (ev_q.hs_fall)                  xa <= '0;
      else if (ev_q.tick && ev_q.blank)  xa <= xa + 10'd1;

      // A line only advances the active-line index if it carried video.
      if (ev_q.vs_fall)                  ya <= '0;
      else if (ev_q.hs_fall && xa != '0) ya <= ya + 10'd1;

      if (ev_q.tick)              to_cnt <= '0;
      else if (to_cnt != TO_MAX)  to_cnt <= to_cnt + TW'(1);

      if (ev_q.tick) begin
        x_q     <= xa;
        y_q     <= ya;
        ativo_q <= ev_q.blank;
      end

      if (ev_q.vs_fall && state_q == TRAVADO) frames_q <= frames_q + 16'd1;
    end
  end

  assign vga.x_rx        = x_q;
  assign vga.y_rx        = y_q;
  assign vga.ativo_rx    = ativo_q;
  assign vga.pixel_valid = pv_q;
  assign vga.frame_start = fs_q;
  assign vga.locked      = (state_q == TRAVADO);
  assign vga.erro        = erro_q;
  assign vga.frames      = frames_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a reduced 32x20 raster (16x12
// active) so that a dozen frames fit in a short run.
module tb_vga_rx_decoder;

  localparam int H   = 32;
  localparam int HA  = 16;
  localparam int V   = 20;
  localparam int VA  = 12;
  localparam int HS0 = HA + 2;
  localparam int HS1 = HS0 + 4;
  localparam int VSP = (VA + 2) * H + HS0;  // raster position of the VS fall
  localparam int FR  = H * V;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  vga_rx_decoder_if vif ();

  vga_rx_decoder #(
    .LOCK_FRAMES(2), .TIMEOUT(64),
    .H_TOT(H), .H_ACT(HA), .V_TOT(V), .V_ACT(VA)
  ) u_dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .vga     (vif)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One pixel period: pins change with VGA_CLK rising, clock high one cycle.
  task automatic pix(input int p);
    int h, v;
    h = p % H;
    v = p / H;
    @(negedge CLOCK_50);
    vif.VGA_BLANK_N = (h < HA) && (v < VA);
    vif.VGA_HS      = !(h >= HS0 && h < HS1);
    vif.VGA_VS      = !(p >= VSP && p < VSP + 2 * H);
    vif.VGA_CLK     = 1'b1;
    @(negedge CLOCK_50);
    vif.VGA_CLK = 1'b0;
  endtask

  task automatic run_span(input int p_from, input int p_to, input int short_v);
    for (int p = p_from; p <= p_to; p++) begin
      if (!(p / H == short_v && p % H == H - 1)) pix(p);
    end
  endtask

  task automatic full_frame();
    run_span(VSP + 1, FR - 1, -1);
    run_span(0, VSP, -1);
  endtask

  task automatic settle();
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " x_rx"},        vif.x_rx,        0);
    check({tag, " y_rx"},        vif.y_rx,        0);
    check({tag, " ativo_rx"},    vif.ativo_rx,    0);
    check({tag, " pixel_valid"}, vif.pixel_valid, 0);
    check({tag, " frame_start"}, vif.frame_start, 0);
    check({tag, " locked"},      vif.locked,      0);
    check({tag, " erro"},        vif.erro,        0);
    check({tag, " frames"},      vif.frames,      0);
  endtask

  initial begin
    vif.VGA_CLK     = 1'b0;
    vif.VGA_HS      = 1'b1;
    vif.VGA_VS      = 1'b1;
    vif.VGA_BLANK_N = 1'b0;

    // Reset state.
    repeat (3) @(negedge CLOCK_50);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Sync VS edge, then two clean frames; lock 3 cycles after the last VS.
    run_span(0, VSP, -1);
    settle();
    check("after first vs locked", vif.locked, 0);
    full_frame();
    settle();
    check("one good frame locked", vif.locked, 0);
    run_span(VSP + 1, FR - 1, -1);
    run_span(0, VSP, -1);
    @(negedge CLOCK_50);
    check("lock latency 2 cycles", vif.locked, 0);
    @(negedge CLOCK_50);
    check("lock latency 3 cycles", vif.locked, 1);
    check("frame_start at lock", vif.frame_start, 1);
    check("erro clean frames", vif.erro, 0);
    check("frames at lock", vif.frames, 0);

    // First and last active pixels of the next frame.
    run_span(VSP + 1, FR - 1, -1);
    run_span(0, 0, -1);
    @(negedge CLOCK_50);
    check("pixel_valid after 2 cycles", vif.pixel_valid, 0);
    @(negedge CLOCK_50);
    check("pixel_valid after 3 cycles", vif.pixel_valid, 1);
    check("first x_rx", vif.x_rx, 0);
    check("first y_rx", vif.y_rx, 0);
    check("first ativo_rx", vif.ativo_rx, 1);
    run_span(1, (VA - 1) * H + HA - 1, -1);
    settle();
    check("last x_rx", vif.x_rx, HA - 1);
    check("last y_rx", vif.y_rx, VA - 1);
    check("last ativo_rx", vif.ativo_rx, 1);
    run_span((VA - 1) * H + HA, VSP, -1);
    settle();
    check("frames counts locked frame", vif.frames, 1);

    // Short line (one tick missing) while locked.
    run_span(VSP + 1, FR - 1, -1);
    run_span(0, 4 * H + HS0, 3);
    @(negedge CLOCK_50);
    check("short line locked before", vif.locked, 1);
    @(negedge CLOCK_50);
    check("short line locked", vif.locked, 0);
    check("short line erro", vif.erro, 1);
    run_span(4 * H + HS0 + 1, VSP, -1);
    settle();
    check("relock after sync", vif.locked, 0);
    full_frame();
    settle();
    check("relock after 1 frame", vif.locked, 0);
    full_frame();
    settle();
    check("relock after 2 frames", vif.locked, 1);

    // Reset pulse mid-frame.
    run_span(VSP + 1, 5 * H + 7, -1);
    @(negedge CLOCK_50);
    check("locked before reset", vif.locked, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid-frame reset");
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    run_span(5 * H + 8, VSP, -1);
    settle();
    check("post-reset sync locked", vif.locked, 0);
    full_frame();
    settle();
    check("post-reset 1 frame locked", vif.locked, 0);
    full_frame();
    settle();
    check("post-reset 2 frames locked", vif.locked, 1);
    check("post-reset erro", vif.erro, 0);

    // Frame counter wrap.
    @(negedge CLOCK_50);
    force u_dut.frames_q = 16'hFFFF;
    @(negedge CLOCK_50);
    release u_dut.frames_q;
    check("frames preload", vif.frames, 16'hFFFF);
    full_frame();
    settle();
    check("frames wrap", vif.frames, 0);
    check("locked after wrap", vif.locked, 1);

    // Pixel clock stalls while locked.
    repeat (60) @(negedge CLOCK_50);
    check("stall 60 locked", vif.locked, 1);
    check("stall 60 erro", vif.erro, 0);
    repeat (10) @(negedge CLOCK_50);
    check("timeout locked", vif.locked, 0);
    check("timeout erro", vif.erro, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
